// File: rtl/ram_ctrl_if.sv
// Request/response bundle for the ram_ctrl data memory.
// The master drives requests; the slave (ram_ctrl) returns registered responses and status.
interface ram_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, access, addr, wdata,
        input  req_ready, resp_valid, rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, access, addr, wdata,
        output req_ready, resp_valid, rdata, resp_err, busy
    );
endinterface

// File: rtl/ram_ctrl.sv
// Word-organised RV32 data memory with byte-lane loads/stores, access checking
// and an optional post-reset clear sweep.
module ram_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ram_ctrl_if.slave  bus
);
    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state;
    logic [WORD_AW-1:0]  clear_ptr;
    logic [31:0]         mem [DEPTH];

    logic                resp_valid_q;
    logic                resp_err_q;
    logic [31:0]         rdata_q;

    logic [WORD_AW-1:0]  word_idx;
    logic [1:0]          lane;
    logic                accept;
    logic                addr_oob;
    logic                acc_legal;
    logic                misaligned;
    logic                req_err;
    logic [3:0]          byte_en;
    logic [31:0]         wr_word;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         load_val;

    // Request decode: legality, lane enables, replicated store data, load extraction.
    always_comb begin
        word_idx   = bus.addr[ADDR_WIDTH-1:2];
        lane       = bus.addr[1:0];
        accept     = bus.req_valid && (state == S_RUN);
        addr_oob   = (bus.addr >> ADDR_WIDTH) != 32'd0;
        acc_legal  = 1'b0;
        misaligned = 1'b0;
        case (bus.access)
            3'b000, 3'b100: acc_legal = 1'b1;
            3'b001, 3'b101: begin
                acc_legal  = 1'b1;
                misaligned = lane[0];
            end
            3'b010: begin
                acc_legal  = 1'b1;
                misaligned = (lane != 2'b00);
            end
            default: acc_legal = 1'b0;
        endcase
        req_err = addr_oob || !acc_legal || (bus.req_we && bus.access[2]) || misaligned;

        case (bus.access[1:0])
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_word = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{bus.wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = bus.wdata;
            end
        endcase

        rd_word = mem[word_idx];
        rd_byte = 8'(rd_word >> {lane, 3'b000});
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (bus.access)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Array port: the clear sweep owns the write port until the FSM reaches RUN.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clear_ptr] <= 32'd0;
        end else if (accept && bus.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // Sweep FSM and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clear_ptr    <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clear_ptr <= clear_ptr + WORD_AW'(1);
                    if (clear_ptr == WORD_AW'(DEPTH - 1)) state <= S_RUN;
                end
                default: state <= S_RUN;
            endcase
            resp_valid_q <= accept;
            resp_err_q   <= accept && req_err;
            rdata_q      <= (accept && !req_err && !bus.req_we) ? load_val : 32'd0;
        end
    end

    assign bus.req_ready  = (state == S_RUN);
    assign bus.busy       = (state == S_CLEAR);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.rdata      = rdata_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_ram_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst_nc;

    always #5 clk = ~clk;

    ram_ctrl_if u ();
    ram_ctrl_if n ();

    ram_ctrl #(.ADDR_WIDTH(12), .CLEAR_ON_RESET(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u)
    );

    ram_ctrl #(.ADDR_WIDTH(12), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk (clk),
        .rst (rst_nc),
        .bus (n)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] model [4096];
    logic [2:0] legal_acc [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reference: byte-addressed memory, size = 2^access[1:0], sign via two's-complement wrap.
    function automatic void model_op(input logic we, input logic [2:0] acc, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] exp_d,
                                     output logic exp_e);
        int     size;
        bit     legal;
        longint v;
        legal = (acc inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        size  = 1 << acc[1:0];
        exp_d = 32'd0;
        exp_e = 1'b0;
        if (!legal || a >= 32'd4096 || (we && acc[2]) || (a % size) != 0) begin
            exp_e = 1'b1;
            return;
        end
        if (we) begin
            for (int k = 0; k < size; k++) model[a + k] = wd[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(model[a + k]) << (8 * k));
            if (!acc[2] && size < 4 && model[a + size - 1][7]) v = v - (longint'(1) << (8 * size));
            exp_d = 32'(v);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4096; k++) model[k] = 8'h00;
    endfunction

    task automatic drive(input logic v, input logic we, input logic [2:0] acc,
                         input logic [31:0] a, input logic [31:0] wd);
        u.req_valid = v;
        u.req_we    = we;
        u.access    = acc;
        u.addr      = a;
        u.wdata     = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        logic [31:0] ed;
        logic ee;
        rst = 1'b1;
        rst_nc = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (3) step();
        checks++;
        if (u.resp_valid !== 1'b0 || u.rdata !== 32'd0 || u.resp_err !== 1'b0 ||
            u.busy !== 1'b1 || u.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b rdata=%h err=%b busy=%b ready=%b, want 0 0 0 1 0",
                     u.resp_valid, u.rdata, u.resp_err, u.busy, u.req_ready);
        end
        rst = 1'b0;
        rst_nc = 1'b0;
        model_clear();
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (u.req_ready !== 1'b0 || u.busy !== 1'b1 || u.resp_valid !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sweep_hold: got %0d bad cycles, want 0", bad);
        end
        checks++;
        if (u.req_ready !== 1'b1 || u.busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: got ready=%b busy=%b, want ready=1 busy=0", u.req_ready, u.busy);
        end
        model_op(1'b0, 3'b010, 32'h0, 32'h0, ed, ee);
        step();
        checks++;
        if (u.resp_valid !== 1'b1 || u.rdata !== 32'd0 || u.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL cleared_lw0: got valid=%b rdata=%h err=%b, want 1 00000000 0",
                     u.resp_valid, u.rdata, u.resp_err);
        end
        drive(1'b1, 1'b0, 3'b010, 32'hFFC, 32'h0);
        step();
        checks++;
        if (u.resp_valid !== 1'b1 || u.rdata !== 32'd0 || u.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL cleared_lwffc: got valid=%b rdata=%h err=%b, want 1 00000000 0",
                     u.resp_valid, u.rdata, u.resp_err);
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_lanes();
        logic [31:0] ta [8];
        logic [2:0]  tc [8];
        logic [31:0] te [8];
        logic [31:0] ed;
        logic        ee;
        ta = '{32'h100, 32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h100, 32'h103};
        tc = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        te = '{32'h0, 32'h00000001, 32'h0000007F, 32'h0000007F,
               32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01, 32'hFFFFFF80};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, tc[i], ta[i], 32'h80FF7F01);
            model_op(i == 0, tc[i], ta[i], 32'h80FF7F01, ed, ee);
            step();
            checks++;
            if (u.resp_valid !== 1'b1 || u.rdata !== te[i] || u.resp_err !== 1'b0) begin
                errors++;
                $display("FAIL lanes[%0d]: got valid=%b rdata=%h err=%b, want 1 %h 0",
                         i, u.resp_valid, u.rdata, u.resp_err, te[i]);
            end
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
        checks++;
        if (u.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_resp: got valid=%b, want 0", u.resp_valid);
        end
    endtask

    task automatic test_store_forward();
        logic        tw [5];
        logic [2:0]  tc [5];
        logic [31:0] ta [5];
        logic [31:0] td [5];
        logic [31:0] te [5];
        logic [31:0] ed;
        logic        ee;
        tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tc = '{3'b000, 3'b010, 3'b001, 3'b010, 3'b100};
        ta = '{32'h203, 32'h200, 32'h200, 32'h200, 32'h203};
        td = '{32'h000000AA, 32'h0, 32'h00001234, 32'h0, 32'h0};
        te = '{32'h0, 32'hAA000000, 32'h0, 32'hAA001234, 32'h000000AA};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tw[i], tc[i], ta[i], td[i]);
            model_op(tw[i], tc[i], ta[i], td[i], ed, ee);
            step();
            checks++;
            if (u.resp_valid !== 1'b1 || u.rdata !== te[i] || u.resp_err !== 1'b0) begin
                errors++;
                $display("FAIL forward[%0d]: got valid=%b rdata=%h err=%b, want 1 %h 0",
                         i, u.resp_valid, u.rdata, u.resp_err, te[i]);
            end
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_errors();
        logic        tw [7];
        logic [2:0]  tc [7];
        logic [31:0] ta [7];
        logic [31:0] tv [7];
        logic [31:0] ed;
        logic        ee;
        tw = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tc = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b010, 3'b001};
        ta = '{32'h101, 32'h102, 32'h1000, 32'h100, 32'h100, 32'h102, 32'h201};
        tv = '{32'h100, 32'h100, 32'h000, 32'h100, 32'h100, 32'h100, 32'h200};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tw[i], tc[i], ta[i], 32'hDEADBEEF);
            model_op(tw[i], tc[i], ta[i], 32'hDEADBEEF, ed, ee);
            step();
            checks++;
            if (u.resp_valid !== 1'b1 || u.rdata !== 32'd0 || u.resp_err !== 1'b1) begin
                errors++;
                $display("FAIL err[%0d]: got valid=%b rdata=%h err=%b, want 1 00000000 1",
                         i, u.resp_valid, u.rdata, u.resp_err);
            end
            drive(1'b1, 1'b0, 3'b010, tv[i], 32'h0);
            model_op(1'b0, 3'b010, tv[i], 32'h0, ed, ee);
            step();
            checks++;
            if (u.resp_valid !== 1'b1 || u.rdata !== ed || u.resp_err !== 1'b0) begin
                errors++;
                $display("FAIL err_unchanged[%0d]: got valid=%b rdata=%h err=%b, want 1 %h 0",
                         i, u.resp_valid, u.rdata, u.resp_err, ed);
            end
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_random();
        logic        v;
        logic        we;
        logic [2:0]  acc;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        logic        ee;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            acc = ($urandom_range(0, 9) < 8) ? legal_acc[$urandom_range(0, 4)] : 3'($urandom);
            a   = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            wd  = 32'($urandom);
            drive(v, we, acc, a, wd);
            ed = 32'd0;
            ee = 1'b0;
            if (v) model_op(we, acc, a, wd, ed, ee);
            step();
            checks++;
            if (v && (u.resp_valid !== 1'b1 || u.rdata !== ed || u.resp_err !== ee)) begin
                errors++;
                $display("FAIL rand[%0d] we=%b acc=%b addr=%h: got valid=%b rdata=%h err=%b, want 1 %h %b",
                         i, we, acc, a, u.resp_valid, u.rdata, u.resp_err, ed, ee);
            end else if (!v && u.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle[%0d]: got valid=%b, want 0", i, u.resp_valid);
            end
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] ed;
        logic        ee;
        int          bad;
        drive(1'b1, 1'b1, 3'b010, 32'h040, 32'h12345678);
        model_op(1'b1, 3'b010, 32'h040, 32'h12345678, ed, ee);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h040, 32'h0);
        step();
        checks++;
        if (u.resp_valid !== 1'b1 || u.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL pre_reset_lw: got valid=%b rdata=%h, want 1 12345678", u.resp_valid, u.rdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (u.resp_valid !== 1'b0 || u.rdata !== 32'd0 || u.req_ready !== 1'b0 || u.busy !== 1'b1) begin
            errors++;
            $display("FAIL async_drop: got valid=%b rdata=%h ready=%b busy=%b, want 0 00000000 0 1",
                     u.resp_valid, u.rdata, u.req_ready, u.busy);
        end
        step();
        rst = 1'b0;
        repeat (300) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (u.req_ready !== 1'b0 || u.busy !== 1'b1 || u.resp_valid !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0 || u.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resweep: got %0d bad cycles ready=%b, want 0 bad and ready=1", bad, u.req_ready);
        end
        step();
        checks++;
        if (u.resp_valid !== 1'b1 || u.rdata !== 32'd0 || u.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resweep_lw40: got valid=%b rdata=%h err=%b, want 1 00000000 0",
                     u.resp_valid, u.rdata, u.resp_err);
        end
        drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        checks++;
        if (u.resp_valid !== 1'b1 || u.rdata !== 32'd0 || u.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resweep_lw100: got valid=%b rdata=%h err=%b, want 1 00000000 0",
                     u.resp_valid, u.rdata, u.resp_err);
        end
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_no_clear();
        rst_nc = 1'b1;
        #1;
        checks++;
        if (n.req_ready !== 1'b1 || n.busy !== 1'b0 || n.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL nc_reset: got ready=%b busy=%b valid=%b, want 1 0 0",
                     n.req_ready, n.busy, n.resp_valid);
        end
        step();
        rst_nc = 1'b0;
        n.req_valid = 1'b1;
        n.req_we    = 1'b1;
        n.access    = 3'b010;
        n.addr      = 32'h004;
        n.wdata     = 32'hCAFEF00D;
        step();
        checks++;
        if (n.resp_valid !== 1'b1 || n.rdata !== 32'd0 || n.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL nc_sw: got valid=%b rdata=%h err=%b, want 1 00000000 0",
                     n.resp_valid, n.rdata, n.resp_err);
        end
        n.req_we = 1'b0;
        step();
        checks++;
        if (n.resp_valid !== 1'b1 || n.rdata !== 32'hCAFEF00D || n.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL nc_lw: got valid=%b rdata=%h err=%b, want 1 cafef00d 0",
                     n.resp_valid, n.rdata, n.resp_err);
        end
        n.access = 3'b001;
        n.addr   = 32'h006;
        step();
        checks++;
        if (n.resp_valid !== 1'b1 || n.rdata !== 32'hFFFFCAFE || n.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL nc_lh: got valid=%b rdata=%h err=%b, want 1 ffffcafe 0",
                     n.resp_valid, n.rdata, n.resp_err);
        end
        n.req_valid = 1'b0;
        step();
        checks++;
        if (n.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL nc_idle: got valid=%b, want 0", n.resp_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n.req_valid = 1'b0;
        n.req_we    = 1'b0;
        n.access    = 3'b010;
        n.addr      = 32'h0;
        n.wdata     = 32'h0;
        test_reset();
        test_lanes();
        test_store_forward();
        test_errors();
        test_random();
        test_reset_mid();
        test_no_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
